// File: rtl/uart_rx.sv
// uart_rx - UART receive core.
//
// Oversamples the synchronised serial line RX_IN at PRESCALE clocks per bit.
// It checks the start, optional parity and stop bits. Each good byte is
// presented on P_DATA together with a one-cycle DATA_VALID strobe. Frames
// arrive LSB first.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : each bit is a 2-of-3 majority of the samples taken at
//               edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
//   undefined : each bit is a single sample taken at edge_cnt = PRESCALE/2.
//   The decision edge and all latencies are the same in both builds.
//
// Ports:
//   CLK        in   oversampling clock (PRESCALE x baud)
//   RST        in   asynchronous reset, active-low
//   RX_IN      in   serial line, idle high, already synchronised
//   PRESCALE   in   [5:0] clocks per bit (8, 16 or 32), latched at start
//   PAR_EN     in   parity bit present, latched at start
//   PAR_TYP    in   0 = even, 1 = odd parity, latched at start
//   P_DATA     out  [DATA_WIDTH-1:0] last correctly received byte
//   DATA_VALID out  one-cycle strobe when P_DATA is updated
//   PAR_ERR    out  parity mismatch in the current or last frame
//   STP_ERR    out  stop bit sampled low in the current or last frame
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Expected parity bit for the received data word.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic odd);
    return odd ? ~(^d) : (^d);
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                  state, state_nxt;
  logic [5:0]              edge_cnt;
  logic [5:0]              presc_q;
  logic [5:0]              half;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    sample;

  logic                    start_det;
  logic                    bit_end;
  logic                    last_bit;
  logic                    shift_en;
  logic                    par_chk;
  logic                    stop_chk;

  assign half      = {1'b0, presc_q[5:1]};
  assign start_det = (state == IDLE) && !RX_IN;
  assign bit_end   = (state != IDLE) && (edge_cnt == presc_q - 6'd1);
  assign last_bit  = (bit_cnt == BW'(DATA_WIDTH - 1));

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic: only the bit-decision edge moves the frame forward,
  // so line activity inside a frame can never restart it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!RX_IN) state_nxt = START;
      START:   if (bit_end) state_nxt = sample ? IDLE : DATA;
      DATA:    if (bit_end && last_bit) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode: per-state decision strobes
  always_comb begin
    shift_en = 1'b0;
    par_chk  = 1'b0;
    stop_chk = 1'b0;
    case (state)
      DATA:    shift_en = bit_end;
      PARITY:  par_chk  = bit_end;
      STOP:    stop_chk = bit_end;
      default: ;
    endcase
  end

  // Frame control: counters and per-frame configuration. The first low cycle
  // seen in IDLE is bit cycle 0, so the counter resumes at 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      if (start_det) begin
        edge_cnt  <= 6'd1;
        bit_cnt   <= '0;
        presc_q   <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end else if (state != IDLE) begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      end
      if (shift_en) bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
    end
  end

  // Sample stage: the bit value becomes valid mid-bit, well before the
  // decision edge at edge_cnt == PRESCALE-1.
`ifdef UART_RX_MAJORITY_EN
  logic s_p0;
  logic s_p1;

  always_ff @(posedge CLK) begin
    if (edge_cnt == half - 6'd1) s_p0 <= RX_IN;
    if (edge_cnt == half)        s_p1 <= RX_IN;
    if (edge_cnt == half + 6'd1) sample <= maj3(s_p0, s_p1, RX_IN);
  end
`else
  always_ff @(posedge CLK) begin
    if (edge_cnt == half) sample <= RX_IN;
  end
`endif

  // Shift stage: data arrives LSB first, so each bit enters at the top.
  always_ff @(posedge CLK) begin
    if (shift_en) shreg <= {sample, shreg[DATA_WIDTH-1:1]};
  end

  // Result stage: error flags and byte delivery
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      if (start_det) begin
        PAR_ERR <= 1'b0;
        STP_ERR <= 1'b0;
      end
      if (par_chk && (sample != parity_bit(shreg, par_typ_q))) PAR_ERR <= 1'b1;
      if (stop_chk) begin
        if (!sample) STP_ERR <= 1'b1;
        // STP_ERR is always clear here, so a high stop bit with no parity
        // error is the whole acceptance test.
        if (sample && !PAR_ERR) begin
          P_DATA     <= shreg;
          DATA_VALID <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e0_cyc   = 0;
  int vld_total = 0;
  int last_vld_cyc = -1;
  logic [7:0] vld_data [0:31];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Each negedge with DATA_VALID high counts once, so a two-cycle strobe
  // shows up as two entries.
  always @(negedge CLK) begin
    if (DATA_VALID) begin
      vld_data[vld_total % 32] = P_DATA;
      last_vld_cyc = cyc;
      vld_total = vld_total + 1;
    end
  end

  // Drive one frame; every bit lasts p cycles, changes at the negedge.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                            input bit ptyp, input bit flip_par, input bit stop_v,
                            input int glitch_bit);
    logic [10:0] bits;
    int n;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pen) begin
      bits[9]  = (ptyp ? ~(^d) : (^d)) ^ flip_par;
      bits[10] = stop_v;
      n = 11;
    end else begin
      bits[9]  = stop_v;
      bits[10] = 1'b1;
      n = 10;
    end
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < p; i++) begin
        @(negedge CLK);
        RX_IN = (b == glitch_bit && i == p / 2) ? ~bits[b] : bits[b];
        if (b == 0 && i == 0) e0_cyc = cyc + 1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++; if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_pdata: got %h expected 00", P_DATA); end
    n_checks++; if (DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", DATA_VALID); end
    n_checks++; if (PAR_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_parerr: got %b expected 0", PAR_ERR); end
    n_checks++; if (STP_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_stperr: got %b expected 0", STP_ERR); end
    RST = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_good_frame;
    int base;
    base = vld_total;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_cycles(4);
    n_checks++; if (vld_total - base !== 1) begin n_fail++; $display("FAIL good_strobes: got %0d expected 1", vld_total - base); end
    n_checks++; if (last_vld_cyc !== e0_cyc + 79) begin n_fail++; $display("FAIL good_latency: got E0+%0d expected E0+79", last_vld_cyc - e0_cyc); end
    n_checks++; if (P_DATA !== 8'hA5) begin n_fail++; $display("FAIL good_pdata: got %h expected a5", P_DATA); end
    n_checks++; if (PAR_ERR !== 1'b0) begin n_fail++; $display("FAIL good_parerr: got %b expected 0", PAR_ERR); end
    n_checks++; if (STP_ERR !== 1'b0) begin n_fail++; $display("FAIL good_stperr: got %b expected 0", STP_ERR); end
  endtask

  task automatic test_start_glitch;
    int base;
    base = vld_total;
    PRESCALE = 6'd16;
    PAR_EN   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      RX_IN = (i < 2) ? 1'b0 : 1'b1;
      if (i == 0) e0_cyc = cyc + 1;
      if (cyc == e0_cyc + 14) begin
        n_checks++; if (int'(dut.state) !== 1) begin n_fail++; $display("FAIL glitch_in_start: state %0d expected 1", int'(dut.state)); end
      end
      if (cyc == e0_cyc + 15) begin
        n_checks++; if (int'(dut.state) !== 0) begin n_fail++; $display("FAIL glitch_idle: state %0d expected 0", int'(dut.state)); end
      end
    end
    n_checks++; if (vld_total - base !== 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", vld_total - base); end
    n_checks++; if (P_DATA !== 8'hA5) begin n_fail++; $display("FAIL glitch_pdata: got %h expected a5", P_DATA); end
    n_checks++; if (PAR_ERR !== 1'b0 || STP_ERR !== 1'b0) begin n_fail++; $display("FAIL glitch_flags: got %b%b expected 00", PAR_ERR, STP_ERR); end
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_cycles(4);
    n_checks++; if (vld_total - base !== 1) begin n_fail++; $display("FAIL glitch_next_strobes: got %0d expected 1", vld_total - base); end
    n_checks++; if (P_DATA !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_pdata: got %h expected 5a", P_DATA); end
  endtask

  task automatic test_parity_err;
    int base;
    base = vld_total;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    idle_cycles(4);
    n_checks++; if (PAR_ERR !== 1'b1) begin n_fail++; $display("FAIL par_parerr: got %b expected 1", PAR_ERR); end
    n_checks++; if (STP_ERR !== 1'b0) begin n_fail++; $display("FAIL par_stperr: got %b expected 0", STP_ERR); end
    n_checks++; if (vld_total - base !== 0) begin n_fail++; $display("FAIL par_strobes: got %0d expected 0", vld_total - base); end
    n_checks++; if (P_DATA !== 8'h5A) begin n_fail++; $display("FAIL par_pdata: got %h expected 5a", P_DATA); end
  endtask

  task automatic test_stop_err;
    int base;
    base = vld_total;
    send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles(4);
    n_checks++; if (STP_ERR !== 1'b1) begin n_fail++; $display("FAIL stop_stperr: got %b expected 1", STP_ERR); end
    n_checks++; if (PAR_ERR !== 1'b0) begin n_fail++; $display("FAIL stop_parerr: got %b expected 0", PAR_ERR); end
    n_checks++; if (vld_total - base !== 0) begin n_fail++; $display("FAIL stop_strobes: got %0d expected 0", vld_total - base); end
    n_checks++; if (P_DATA !== 8'h5A) begin n_fail++; $display("FAIL stop_pdata: got %h expected 5a", P_DATA); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] exp_d [0:2];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h81;
    base = vld_total;
    for (int f = 0; f < 3; f++) send_frame(exp_d[f], 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_cycles(4);
    n_checks++; if (vld_total - base !== 3) begin n_fail++; $display("FAIL b2b_strobes: got %0d expected 3", vld_total - base); end
    for (int f = 0; f < 3; f++) begin
      n_checks++;
      if (vld_data[(base + f) % 32] !== exp_d[f]) begin
        n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", f, vld_data[(base + f) % 32], exp_d[f]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    base = vld_total;
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    @(negedge CLK);
    RST   = 1'b0;
    RX_IN = 1'b1;
    #1;
    n_checks++; if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_mid_pdata: got %h expected 00", P_DATA); end
    n_checks++; if (DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", DATA_VALID); end
    n_checks++; if (PAR_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_mid_parerr: got %b expected 0", PAR_ERR); end
    n_checks++; if (STP_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stperr: got %b expected 0", STP_ERR); end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    idle_cycles(100);
    n_checks++; if (vld_total - base !== 0) begin n_fail++; $display("FAIL rst_mid_strobes: got %0d expected 0", vld_total - base); end
    n_checks++; if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_mid_pdata_after: got %h expected 00", P_DATA); end
  endtask

  task automatic test_majority;
    int base;
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'h00;
`else
    exp_d = 8'h08;
`endif
    base = vld_total;
    // Frame bit 4 is data bit 3.
    send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    idle_cycles(4);
    n_checks++; if (vld_total - base !== 1) begin n_fail++; $display("FAIL maj_strobes: got %0d expected 1", vld_total - base); end
    n_checks++; if (P_DATA !== exp_d) begin n_fail++; $display("FAIL maj_pdata: got %h expected %h", P_DATA, exp_d); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_start_glitch();
    test_parity_err();
    test_stop_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_majority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
